// File: rtl/cpu6502_timer_pkg.sv
// rtl/cpu6502_timer_pkg.sv - shared register map, bit indices and FSM encoding for the interval timer
package cpu6502_timer_pkg;

  localparam logic [1:0] REG_CNT_LO = 2'd0;
  localparam logic [1:0] REG_CNT_HI = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_CONT  = 2;
  localparam int CTRL_W     = 3;

  localparam int STATUS_RUN = 0;
  localparam int STATUS_IF  = 7;

  localparam int PRESCALE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] status_byte(input logic if_flag, input logic running);
    logic [7:0] b;
    b = 8'h00;
    b[STATUS_IF]  = if_flag;
    b[STATUS_RUN] = running;
    return b;
  endfunction

endpackage

// File: rtl/cpu6502_timer_prescale.sv
// rtl/cpu6502_timer_prescale.sv - prescaler producing one tick every PRESCALE clocks while running
module cpu6502_timer_prescale
  import cpu6502_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  logic [PRESCALE_W-1:0] cnt_q;

  assign tick = run && (cnt_q == PRESCALE_W'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!run || clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/cpu6502_timer.sv
// rtl/cpu6502_timer.sv - memory-mapped 16-bit down-counting interval timer with irq for the cpu6502 bus
module cpu6502_timer
  import cpu6502_timer_pkg::*;
#(
  parameter logic [15:0] BASE     = 16'hD000,
  parameter int unsigned PRESCALE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        rw,
  input  logic        clk2,
  output logic [7:0]  rdata,
  output logic        sel,
  output logic        irq
);

  state_e            state_q;
  logic              clk2_q;
  logic [15:0]       count_q;
  logic [15:0]       count_d;
  logic [15:0]       latch_q;
  logic [7:0]        hi_snap_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              if_q;
  logic              if_d;

  logic [15:0] offset;
  logic [1:0]  off;
  logic        strobe;
  logic        wr_lo, wr_hi, wr_ctrl, wr_stat, rd_lo;
  logic        stop;
  logic        running;
  logic        tick;
  logic        tick_ok;
  logic        underflow;

  // Offset arithmetic keeps the decode correct even for a BASE that is not 4-aligned.
  assign offset = addr - BASE;
  assign sel    = (offset[15:2] == 14'd0);
  assign off    = offset[1:0];

  assign strobe  = clk2_q & ~clk2 & sel;
  assign wr_lo   = strobe & ~rw & (off == REG_CNT_LO);
  assign wr_hi   = strobe & ~rw & (off == REG_CNT_HI);
  assign wr_ctrl = strobe & ~rw & (off == REG_CTRL);
  assign wr_stat = strobe & ~rw & (off == REG_STATUS);
  assign rd_lo   = strobe &  rw & (off == REG_CNT_LO);

  assign stop    = wr_ctrl & ~wdata[CTRL_EN];
  assign running = (state_q == ST_RUN);

  // A reload or a disable landing on the tick edge suppresses that tick entirely.
  assign tick_ok   = running & tick & ~wr_hi & ~stop;
  assign underflow = tick_ok & (count_q == 16'd0);

  assign irq = ~(if_q & ctrl_q[CTRL_IE]);

  cpu6502_timer_prescale #(
    .PRESCALE(PRESCALE)
  ) u_prescale (
    .clk  (clk),
    .reset(reset),
    .run  (running),
    .clear(wr_hi | stop),
    .tick (tick)
  );

  always_comb begin
    count_d = count_q;
    if (wr_hi) begin
      count_d = {wdata, latch_q[7:0]};
    end else if (tick_ok) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else if (ctrl_q[CTRL_CONT]) begin
        count_d = latch_q;
      end
    end
  end

  // Set beats write-1-to-clear; a CNT_HI reload beats both.
  always_comb begin
    if_d = if_q;
    if (wr_hi) begin
      if_d = 1'b0;
    end else if (underflow) begin
      if_d = 1'b1;
    end else if (wr_stat && wdata[STATUS_IF]) begin
      if_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      clk2_q    <= 1'b0;
      count_q   <= 16'd0;
      latch_q   <= 16'd0;
      hi_snap_q <= 8'h00;
      ctrl_q    <= '0;
      if_q      <= 1'b0;
    end else begin
      clk2_q  <= clk2;
      count_q <= count_d;
      if_q    <= if_d;

      if (wr_lo) latch_q[7:0]  <= wdata;
      if (wr_hi) latch_q[15:8] <= wdata;
      if (wr_ctrl) ctrl_q <= wdata[CTRL_W-1:0];
      if (rd_lo) hi_snap_q <= count_q[15:8];

      if (wr_hi) begin
        state_q <= ctrl_q[CTRL_EN] ? ST_RUN : ST_IDLE;
      end else if (stop) begin
        state_q <= ST_IDLE;
      end else if (wr_ctrl && (state_q == ST_IDLE) && (count_q != 16'd0)) begin
        state_q <= ST_RUN;
      end else if (underflow && !ctrl_q[CTRL_CONT]) begin
        state_q <= ST_DONE;
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (sel) begin
      case (off)
        REG_CNT_LO: rdata = count_q[7:0];
        REG_CNT_HI: rdata = hi_snap_q;
        REG_CTRL:   rdata = {{(8 - CTRL_W){1'b0}}, ctrl_q};
        default:    rdata = status_byte(if_q, running);
      endcase
    end
  end

endmodule

// File: tb/tb_cpu6502_timer.sv
// tb/tb_cpu6502_timer.sv - randomized self-checking bench for cpu6502_timer against a timing-formula model
module tb_cpu6502_timer;

  localparam logic [15:0] BASE = 16'hD000;
  localparam int P = 8;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr  = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        rw    = 1'b1;
  logic        clk2  = 1'b0;
  logic [7:0]  rdata;
  logic        sel;
  logic        irq;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;

  cpu6502_timer #(
    .BASE    (BASE),
    .PRESCALE(P)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .wdata(wdata),
    .rw   (rw),
    .clk2 (clk2),
    .rdata(rdata),
    .sel  (sel),
    .irq  (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected count k clocks after the load edge: one decrement per P clocks, hold/reload at zero.
  function automatic int model_count(input int n, input int k, input bit cont);
    int period;
    int kk;
    period = (n + 1) * P;
    kk = k;
    if (cont) kk = k % period;
    if (kk >= period) return 0;
    return n - kk / P;
  endfunction

  // One phi2 access; t is the cycle of the strobe, the access takes effect on edge t+1.
  task automatic bus(input logic [1:0] o, input logic r, input logic [7:0] d,
                     output logic [7:0] q, output int t);
    @(posedge clk); #1;
    addr = BASE + 16'(o); rw = r; wdata = d; clk2 = 1'b1;
    @(posedge clk); #1;
    clk2 = 1'b0;
    q = rdata;
    t = cyc;
    @(posedge clk); #1;
    addr = 16'h0000; rw = 1'b1;
  endtask

  task automatic wr(input logic [1:0] o, input logic [7:0] d, output int t);
    logic [7:0] q;
    bus(o, 1'b0, d, q, t);
  endtask

  task automatic rd(input logic [1:0] o, output logic [7:0] q, output int t);
    bus(o, 1'b1, 8'h00, q, t);
  endtask

  task automatic wait_irq_low(input int bound, output int at);
    while (irq !== 1'b0 && cyc < bound) begin
      @(posedge clk); #1;
    end
    at = cyc;
  endtask

  task automatic do_reset();
    addr = 16'h0000; clk2 = 1'b0; rw = 1'b1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    logic [7:0] q, lo, hi, d8;
    int t, tw, at, n, k, e, per, target, m;
    bit cont;

    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_irq", int'(irq), 1);
    chk("rst_sel", int'(sel), 0);
    for (int i = 0; i < 4; i++) begin
      addr = BASE + 16'(i);
      #1;
      chk($sformatf("rst_reg%0d", i), int'(rdata), 0);
    end
    addr = 16'h0000;
    #1 reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      d8 = 8'($urandom);
      wr(2'd2, d8, t);
      rd(2'd2, q, t);
      chk("ctrl_rb", int'(q), int'(d8 & 8'h07));
      rd(2'd3, q, t);
      chk("ctrl_status_idle", int'(q), 0);
      wr(2'd2, 8'h00, t);
    end

    for (int i = 0; i < 5; i++) begin
      do_reset();
      n = (i == 0) ? 4 : int'($urandom_range(0, 300));
      wr(2'd2, 8'h03, t);
      wr(2'd0, 8'(n), t);
      wr(2'd1, 8'(n >> 8), t);
      tw = t + 1;
      repeat ($urandom_range(0, (n + 1) * P - 4)) begin
        @(posedge clk); #1;
      end
      rd(2'd0, lo, t);
      e = model_count(n, t - tw, 1'b0);
      chk("os_mid_lo", int'(lo), e & 8'hFF);
      wait_irq_low(tw + (n + 1) * P + 20, at);
      chk("os_latency", at - tw, (n + 1) * P);
      rd(2'd1, hi, t);
      chk("os_mid_hi", int'(hi), (e >> 8) & 8'hFF);
      rd(2'd3, q, t);
      chk("os_status", int'(q), 8'h80);
      rd(2'd0, lo, t);
      rd(2'd1, hi, t);
      chk("os_hold_lo", int'(lo), 0);
      chk("os_hold_hi", int'(hi), 0);
      chk("os_irq_low", int'(irq), 0);
      wr(2'd3, 8'h80, t);
      chk("os_w1c_irq", int'(irq), 1);
      rd(2'd3, q, t);
      chk("os_status_clr", int'(q), 0);
    end

    for (int i = 0; i < 4; i++) begin
      do_reset();
      n = (i == 0) ? 2 : (i == 1) ? 0 : int'($urandom_range(0, 5));
      per = (n + 1) * P;
      wr(2'd2, 8'h07, t);
      wr(2'd0, 8'(n), t);
      wr(2'd1, 8'h00, t);
      tw = t + 1;
      wait_irq_low(tw + per + 20, at);
      chk("cont_first", at - tw, per);
      wr(2'd3, 8'h80, t);
      chk("cont_w1c_irq", int'(irq), 1);
      rd(2'd3, q, t);
      chk("cont_status", int'(q), 8'h01);
      wait_irq_low(tw + 2 * per + 20, at);
      chk("cont_second", at - tw, 2 * per);
    end

    for (int i = 0; i < 6; i++) begin
      do_reset();
      wr(2'd2, 8'h01, t);
      wr(2'd0, 8'h00, t);
      wr(2'd1, 8'h01, t);
      tw = t + 1;
      repeat ($urandom_range(3, 7)) begin
        @(posedge clk); #1;
      end
      rd(2'd0, lo, t);
      k = t - tw;
      rd(2'd1, hi, t);
      e = model_count(256, k, 1'b0);
      chk("coh_lo", int'(lo), e & 8'hFF);
      chk("coh_hi", int'(hi), (e >> 8) & 8'hFF);
      chk("coh_pair", int'((hi == 8'h01 && lo == 8'h00) || (hi == 8'h00 && lo == 8'hFF)), 1);
    end

    for (int i = 0; i < 3; i++) begin
      do_reset();
      n = int'($urandom_range(1, 5));
      cont = 1'($urandom);
      m = int'($urandom_range(1, 16'hFFFF));
      wr(2'd2, {5'b0, cont, 2'b11}, t);
      wr(2'd0, 8'(n), t);
      wr(2'd1, 8'h00, t);
      tw = t + 1;
      wr(2'd0, 8'(m), t);
      target = tw + (n + 1) * P - 3;
      while (cyc < target) begin
        @(posedge clk); #1;
      end
      wr(2'd1, 8'(m >> 8), t);
      chk("coll_edge", t + 1, tw + (n + 1) * P);
      chk("coll_irq", int'(irq), 1);
      rd(2'd3, q, t);
      chk("coll_status", int'(q), 8'h01);
      rd(2'd0, lo, t);
      rd(2'd1, hi, t);
      chk("coll_count", int'({hi, lo}), m);
    end

    do_reset();
    wr(2'd2, 8'h07, t);
    wr(2'd0, 8'h10, t);
    wr(2'd1, 8'h00, t);
    tw = t + 1;
    wait_irq_low(tw + 17 * P + 20, at);
    chk("ar_latency", at - tw, 17 * P);
    addr = BASE;
    #1;
    chk("ar_pre_count", int'(rdata), 8'h10);
    chk("ar_pre_irq", int'(irq), 0);
    #1 reset = 1'b0;
    #1;
    chk("ar_irq", int'(irq), 1);
    chk("ar_count", int'(rdata), 0);
    addr = BASE + 16'd3;
    #1;
    chk("ar_status", int'(rdata), 0);
    addr = BASE + 16'd2;
    #1;
    chk("ar_ctrl", int'(rdata), 0);
    addr = 16'h0000;
    @(posedge clk); #1 reset = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu6502_timer.md
# cpu6502_timer

Memory-mapped 16-bit interval timer that sits on the cpu6502 data bus next to ROM/RAM and drives the CPU's active-low `irq` input. The CPU programs it with ordinary LDA/STA accesses to four byte registers at a fixed base address. The timer counts down at a prescaled rate and sets an interrupt flag on underflow, either once or with automatic reload. Read data is presented for the top-level read mux together with a select flag.

## Interface
- `BASE`, 16'hD000: address of register 0; registers occupy `BASE`..`BASE+3`.
- `PRESCALE`, 8: `clk` cycles per counter decrement (legal range 1–255).
- `clk`  in  1  system clock, the same clock that drives cpu6502.
- `reset`  in  1  asynchronous, active-low reset.
- `addr`  in  16  CPU address bus.
- `wdata`  in  8  CPU write data (cpu6502 `odata`).
- `rw`  in  1  CPU read/write: 1 = read, 0 = write.
- `clk2`  in  1  CPU phi2 output; an access completes on its falling edge.
- `rdata`  out  8  read data; 8'h00 when `sel` is 0.
- `sel`  out  1  combinational: `addr` is within `BASE`..`BASE+3`.
- `irq`  out  1  active-low interrupt request to cpu6502.

## Operation
- Register map, by offset from `BASE`:
  - 0 `CNT_LO`
    - Write: `latch[7:0]`.
    - Read: `count[7:0]`. The read strobe also snapshots `count[15:8]` into `hi_snap`.
  - 1 `CNT_HI`
    - Write: `latch[15:8]`, then `count <= {wdata, latch[7:0]}`, `IF <= 0`, prescaler cleared. The FSM goes to RUN if `EN` is set, otherwise to IDLE.
    - Read: `hi_snap`.
  - 2 `CTRL`: bit0 `EN`, bit1 `IE`, bit2 `CONT` (1 = auto-reload); bits 7:3 read 0. Writing `EN` = 0 forces IDLE and freezes `count`.
  - 3 `STATUS`
    - Read: `{IF, 6'b0, running}`.
    - Write: bit7 = 1 clears `IF` (write-1-to-clear); other bits are ignored.
- Access strobe: `clk2_q` is `clk2` registered. `strobe = clk2_q & ~clk2 & sel`.
  - Writes (`rw` = 0) and read side effects (`rw` = 1) occur only on `strobe`.
  - `rdata` is combinational from `addr` and register state. Reads have no side effects other than the `hi_snap` capture.
- Prescaler: counts 0..`PRESCALE`-1 while in RUN and asserts `tick` on the terminal value. It is held at 0 outside RUN.
- FSM states:
  - IDLE
    - Exits to RUN on a `CNT_HI` write with `EN` = 1.
    - Exits to RUN on a `CTRL` write setting `EN` = 1 when `count` ≠ 0.
  - RUN
    - On `tick`: if `count` ≠ 0, `count <= count - 1`.
    - On `tick` with `count` == 0: set `IF`.
      - `CONT` = 1: `count <= latch`, stay in RUN.
      - `CONT` = 0: go to DONE.
  - DONE: `count` holds 0. Exits to RUN on a `CNT_HI` write with `EN` = 1, and to IDLE on a `CTRL` write with `EN` = 0.
- `running` = (state == RUN).
- `irq = ~(IF & IE)`.
- Arithmetic: `count` is 16-bit unsigned. Underflow is detected at 0 and never wraps to 16'hFFFF. A latch value of 0 in `CONT` mode sets `IF` on every `tick`.

## Timing
- Reset values:
  - `count` = 0, `latch` = 0, `hi_snap` = 0, `CTRL` = 0, `IF` = 0.
  - State IDLE, prescaler 0, `clk2_q` = 0.
  - Outputs: `irq` = 1, `rdata` = 8'h00 unless `addr` selects a register.
- Register writes take effect on the `clk` edge where `strobe` is high, i.e. one `clk` after the falling edge of `clk2`.
- Load to first `IF`: (N+1)·`PRESCALE` `clk` cycles after the `CNT_HI` write edge, for loaded value N.
- `irq` falls on the same edge that sets `IF` (with `IE` = 1). It rises on the edge that clears `IF` or `IE`.
- Simultaneous events:
  - `CNT_HI` write coinciding with underflow: the write wins; `IF` is cleared.
  - `STATUS` W1C coinciding with an `IF` set: the set wins.
  - `CTRL` `EN` = 0 write coinciding with `tick`: the write wins; `count` is not decremented.
- Asserting reset mid-count returns all state to the reset values immediately, asynchronously.

## Structure
- Shared package `cpu6502_timer_pkg`:
  - Register offsets `REG_CNT_LO`..`REG_STATUS`.
  - `CTRL`/`STATUS` bit indices.
  - FSM state encoding.
- Sub-module `cpu6502_timer_prescale`: the prescaler counter, with inputs `clk`, `reset`, `run`, `clear` and output `tick`.
- Everything else (decode, FSM, registers) lives in the top module.

## Test plan
- **Reset**: hold reset low → `irq` = 1, `sel` = 0 at addr 0, and every register reads 8'h00 at `BASE`+0..3.
- **One-shot**:
  - Stimulus: STA `CTRL` = 8'h03, STA `CNT_LO` = 8'h04, STA `CNT_HI` = 8'h00, `PRESCALE` = 8.
  - Response: `irq` falls exactly 40 `clk` after the `CNT_HI` strobe; `STATUS` reads 8'h80; `count` holds 0 afterwards.
- **Continuous reload**:
  - Stimulus: `CTRL` = 8'h07, latch = 2.
  - Response: `IF` sets every 24 `clk`. A W1C to `STATUS` = 8'h80 returns `irq` to 1 until the next underflow.
- **Coherent read**:
  - Stimulus: load 16'h0100, run, then LDA `CNT_LO` followed by LDA `CNT_HI` across the 16'h0100→16'h00FF boundary.
  - Response: the (hi, lo) pair read is consistent, either (8'h01, 8'h00) or (8'h00, 8'hFF), never (8'h00, 8'h00).
- **Collision**:
  - Stimulus: `CNT_HI` write strobed on the same `clk` as an underflow `tick`.
  - Response: `IF` = 0, `count` = new value, state RUN.
- **Async reset mid-count**:
  - Stimulus: drop reset while `count` = 16'h0010 in RUN.
  - Response: `count` = 0, state IDLE and `irq` = 1 before the next `clk` edge.
